// File: rtl/ooo_types.sv
// ============================================================================
// Module      : ooo_types
// Description : Shared types for the out-of-order core's data-cache port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ooo_types;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        LOAD_BUSY  = 2'd1,
        STORE_BUSY = 2'd2,
        LOAD_DRAIN = 2'd3
    } arb_state_t;

    typedef struct packed {
        logic        read;
        logic        write;
        logic [31:0] address;
        logic [31:0] wdata;
        logic [3:0]  byte_enable;
    } dcache_req_t;

endpackage

`default_nettype wire

// File: rtl/dcache_grant_logic.sv
// ============================================================================
// Module      : dcache_grant_logic
// Description : Load/store arbitration decision with starvation override.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dcache_grant_logic #(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = $clog2(STARVE_LIMIT + 1)
) (
    input  logic             ld_read,
    input  logic             st_write,
    input  logic             flush,
    input  logic [CNT_W-1:0] starve_cnt,
    output logic             grant_load,
    output logic             grant_store
);

    logic load_eligible;
    logic starved;

    // A flush kills any load issued this cycle; stores are already committed.
    assign load_eligible = ld_read && !flush;
    assign starved       = (starve_cnt == CNT_W'(STARVE_LIMIT));
    assign grant_load    = load_eligible && (!st_write || starved);
    assign grant_store   = st_write && !grant_load;

endmodule

`default_nettype wire

// File: rtl/dcache_port_arbiter.sv
// ============================================================================
// Module      : dcache_port_arbiter
// Description : Shares the single data-cache port between loads and stores.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dcache_port_arbiter
    import ooo_types::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = $clog2(STARVE_LIMIT + 1)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        ld_read,
    input  logic [31:0] ld_address,
    output logic        ld_resp,
    output logic [31:0] ld_rdata,
    input  logic        st_write,
    input  logic [31:0] st_address,
    input  logic [31:0] st_wdata,
    input  logic [3:0]  st_byte_enable,
    output logic        st_resp,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_address,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_byte_enable,
    input  logic [31:0] mem_rdata,
    input  logic        mem_resp
);

    arb_state_t       state;
    arb_state_t       state_next;
    logic [31:0]      addr_q;
    logic [31:0]      wdata_q;
    logic [3:0]       be_q;
    logic [CNT_W-1:0] starve_cnt;
    logic [CNT_W-1:0] starve_next;
    logic             grant_load;
    logic             grant_store;
    dcache_req_t      mem_req;

    dcache_grant_logic #(
        .STARVE_LIMIT (STARVE_LIMIT),
        .CNT_W        (CNT_W)
    ) u_grant (
        .ld_read     (ld_read),
        .st_write    (st_write),
        .flush       (flush),
        .starve_cnt  (starve_cnt),
        .grant_load  (grant_load),
        .grant_store (grant_store)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            starve_cnt <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            be_q       <= '0;
        end else begin
            state      <= state_next;
            starve_cnt <= starve_next;
            if (state == IDLE) begin
                if (grant_store) begin
                    addr_q  <= st_address;
                    wdata_q <= st_wdata;
                    be_q    <= st_byte_enable;
                end else if (grant_load) begin
                    addr_q  <= ld_address;
                    wdata_q <= '0;
                    be_q    <= 4'b1111;
                end
            end
        end
    end

    always_comb begin
        state_next  = state;
        starve_next = starve_cnt;
        mem_req     = '{read: 1'b0, write: 1'b0, address: 32'd0,
                        wdata: 32'd0, byte_enable: 4'b1111};
        ld_resp     = 1'b0;
        ld_rdata    = 32'd0;
        st_resp     = 1'b0;

        case (state)
            IDLE: begin
                if (flush || grant_load) begin
                    starve_next = '0;
                end else if (ld_read && grant_store &&
                             starve_cnt != CNT_W'(STARVE_LIMIT)) begin
                    starve_next = starve_cnt + CNT_W'(1);
                end
                if (grant_store) begin
                    state_next = STORE_BUSY;
                end else if (grant_load) begin
                    state_next = LOAD_BUSY;
                end
            end
            LOAD_BUSY: begin
                mem_req.read    = 1'b1;
                mem_req.address = addr_q;
                if (mem_resp) begin
                    ld_resp    = !flush;
                    ld_rdata   = flush ? 32'd0 : mem_rdata;
                    state_next = IDLE;
                end else if (flush) begin
                    state_next = LOAD_DRAIN;
                end
            end
            // The cache cannot abort a read, so the squashed load is waited out.
            LOAD_DRAIN: begin
                mem_req.read    = 1'b1;
                mem_req.address = addr_q;
                if (mem_resp) begin
                    state_next = IDLE;
                end
            end
            STORE_BUSY: begin
                mem_req.write       = 1'b1;
                mem_req.address     = addr_q;
                mem_req.wdata       = wdata_q;
                mem_req.byte_enable = be_q;
                if (mem_resp) begin
                    st_resp    = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign mem_read        = mem_req.read;
    assign mem_write       = mem_req.write;
    assign mem_address     = mem_req.address;
    assign mem_wdata       = mem_req.wdata;
    assign mem_byte_enable = mem_req.byte_enable;

endmodule

`default_nettype wire

// File: tb/tb_dcache_port_arbiter.sv
// ============================================================================
// Module      : tb_dcache_port_arbiter
// Description : Directed vector bench for the data-cache port arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dcache_port_arbiter;

    localparam int K_IDLE = 0;
    localparam int K_LD   = 1;
    localparam int K_ST   = 2;

    typedef struct {
        logic        rst;
        logic        flush;
        logic        ld;
        logic [31:0] la;
        logic        st;
        logic [31:0] sa;
        logic [31:0] sw;
        logic [3:0]  sb;
        logic        mresp;
        logic [31:0] mrdata;
        int          kind;
        logic [31:0] eaddr;
        logic [31:0] edata;
        logic [3:0]  ebe;
        logic        eresp;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        ld_read = 1'b0;
    logic [31:0] ld_address = '0;
    logic        ld_resp;
    logic [31:0] ld_rdata;
    logic        st_write = 1'b0;
    logic [31:0] st_address = '0;
    logic [31:0] st_wdata = '0;
    logic [3:0]  st_byte_enable = '0;
    logic        st_resp;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_address;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_byte_enable;
    logic [31:0] mem_rdata = '0;
    logic        mem_resp = 1'b0;

    int   checks = 0;
    int   errors = 0;
    vec_t vecs[$];

    dcache_port_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk             (clk),
        .rst             (rst),
        .flush           (flush),
        .ld_read         (ld_read),
        .ld_address      (ld_address),
        .ld_resp         (ld_resp),
        .ld_rdata        (ld_rdata),
        .st_write        (st_write),
        .st_address      (st_address),
        .st_wdata        (st_wdata),
        .st_byte_enable  (st_byte_enable),
        .st_resp         (st_resp),
        .mem_read        (mem_read),
        .mem_write       (mem_write),
        .mem_address     (mem_address),
        .mem_wdata       (mem_wdata),
        .mem_byte_enable (mem_byte_enable),
        .mem_rdata       (mem_rdata),
        .mem_resp        (mem_resp)
    );

    always #5 clk = ~clk;

    // Requesters must hold their level until answered, flushed or reset.
    logic p_ld = 1'b0, p_st = 1'b0, p_ldr = 1'b0, p_str = 1'b0, p_fl = 1'b0, p_rst = 1'b1;
    always @(posedge clk) begin
        if (!rst && !p_rst) begin
            assert (!(p_ld && !ld_read && !p_ldr && !p_fl)) else $error("load request dropped early");
            assert (!(p_st && !st_write && !p_str)) else $error("store request dropped early");
        end
        p_ld  <= ld_read;
        p_st  <= st_write;
        p_ldr <= ld_resp;
        p_str <= st_resp;
        p_fl  <= flush;
        p_rst <= rst;
    end

    task automatic add(input logic r, input logic fl, input logic ld, input logic [31:0] la,
                       input logic st, input logic [31:0] sa, input logic [31:0] sw, input logic [3:0] sb,
                       input logic mr, input logic [31:0] mrd, input int k,
                       input logic [31:0] ea, input logic [31:0] ed, input logic [3:0] eb, input logic er);
        vec_t v;
        v.rst = r; v.flush = fl; v.ld = ld; v.la = la;
        v.st = st; v.sa = sa; v.sw = sw; v.sb = sb;
        v.mresp = mr; v.mrdata = mrd; v.kind = k;
        v.eaddr = ea; v.edata = ed; v.ebe = eb; v.eresp = er;
        vecs.push_back(v);
    endtask

    task automatic idle_vec(input logic fl, input logic ld, input logic [31:0] la, input logic st,
                            input logic [31:0] sa, input logic [31:0] sw, input logic [3:0] sb);
        add(0, fl, ld, la, st, sa, sw, sb, 0, 0, K_IDLE, 0, 0, 0, 0);
    endtask

    // Order: ld_resp, ld_rdata, st_resp, mem_read, mem_write, mem_address, mem_wdata, mem_byte_enable
    function automatic logic [103:0] expect_of(input vec_t v);
        logic [103:0] e;
        e = {1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'b1111};
        if (v.kind == K_LD)
            e = {v.eresp, (v.eresp ? v.edata : 32'd0), 1'b0, 1'b1, 1'b0, v.eaddr, 32'd0, 4'b1111};
        else if (v.kind == K_ST)
            e = {1'b0, 32'd0, v.eresp, 1'b0, 1'b1, v.eaddr, v.edata, v.ebe};
        return e;
    endfunction

    function automatic logic [103:0] actual();
        return {ld_resp, ld_rdata, st_resp, mem_read, mem_write, mem_address, mem_wdata, mem_byte_enable};
    endfunction

    task automatic check(input string name, input logic [103:0] act, input logic [103:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        logic [103:0] e;
        bit           found;
        int           gap;

        // reset state, lone load with 3-cycle cache latency
        idle_vec(0, 0, 0, 0, 0, 0, 0);
        idle_vec(0, 1, 'h100, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) add(0, 0, 1, 'h100, 0, 0, 0, 0, 0, 0, K_LD, 'h100, 0, 0, 0);
        add(0, 0, 1, 'h100, 0, 0, 0, 0, 1, 'hDEADBEEF, K_LD, 'h100, 'hDEADBEEF, 0, 1);
        idle_vec(0, 0, 0, 0, 0, 0, 0);
        // lone store
        idle_vec(0, 0, 0, 1, 'h204, 'h0000AB00, 4'b0010);
        add(0, 0, 0, 0, 1, 'h204, 'h0000AB00, 4'b0010, 0, 0, K_ST, 'h204, 'h0000AB00, 4'b0010, 0);
        add(0, 0, 0, 0, 1, 'h204, 'h0000AB00, 4'b0010, 1, 0, K_ST, 'h204, 'h0000AB00, 4'b0010, 1);
        idle_vec(0, 0, 0, 0, 0, 0, 0);
        // simultaneous: store first, then load
        idle_vec(0, 1, 'h300, 1, 'h400, 'h11223344, 4'hF);
        add(0, 0, 1, 'h300, 1, 'h400, 'h11223344, 4'hF, 1, 0, K_ST, 'h400, 'h11223344, 4'hF, 1);
        idle_vec(0, 1, 'h300, 0, 0, 0, 0);
        add(0, 0, 1, 'h300, 0, 0, 0, 0, 1, 'h55, K_LD, 'h300, 'h55, 0, 1);
        idle_vec(0, 0, 0, 0, 0, 0, 0);
        // starvation: four store wins, load forced on the fifth round
        for (int r = 0; r < 4; r++) begin
            idle_vec(0, 1, 'h500, 1, 'h600, 'hCAFEF00D, 4'b1100);
            add(0, 0, 1, 'h500, 1, 'h600, 'hCAFEF00D, 4'b1100, 1, 0, K_ST, 'h600, 'hCAFEF00D, 4'b1100, 1);
        end
        idle_vec(0, 1, 'h500, 1, 'h600, 'hCAFEF00D, 4'b1100);
        add(0, 0, 1, 'h500, 1, 'h600, 'hCAFEF00D, 4'b1100, 1, 'h0BADC0DE, K_LD, 'h500, 'h0BADC0DE, 0, 1);
        idle_vec(0, 1, 'h504, 1, 'h600, 'hCAFEF00D, 4'b1100);
        add(0, 0, 1, 'h504, 1, 'h600, 'hCAFEF00D, 4'b1100, 1, 0, K_ST, 'h600, 'hCAFEF00D, 4'b1100, 1);
        idle_vec(0, 1, 'h504, 0, 0, 0, 0);
        add(0, 0, 1, 'h504, 0, 0, 0, 0, 1, 'h77, K_LD, 'h504, 'h77, 0, 1);
        idle_vec(0, 0, 0, 0, 0, 0, 0);
        // flush in LOAD_BUSY before the response: drain, data swallowed
        idle_vec(0, 1, 'h700, 0, 0, 0, 0);
        add(0, 1, 1, 'h700, 0, 0, 0, 0, 0, 0, K_LD, 'h700, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, K_LD, 'h700, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0, 1, 'h12345678, K_LD, 'h700, 0, 0, 0);
        idle_vec(0, 0, 0, 0, 0, 0, 0);
        // flush coincident with the response, then flush in IDLE with both requesting
        idle_vec(0, 1, 'h800, 0, 0, 0, 0);
        add(0, 1, 1, 'h800, 0, 0, 0, 0, 1, 'hAAAA, K_LD, 'h800, 0, 0, 0);
        idle_vec(1, 1, 'h804, 1, 'h808, 'h99, 4'b0001);
        add(0, 0, 1, 'h804, 1, 'h808, 'h99, 4'b0001, 1, 0, K_ST, 'h808, 'h99, 4'b0001, 1);
        idle_vec(0, 1, 'h804, 0, 0, 0, 0);
        add(0, 0, 1, 'h804, 0, 0, 0, 0, 1, 'h44, K_LD, 'h804, 'h44, 0, 1);
        idle_vec(0, 0, 0, 0, 0, 0, 0);
        // flush in IDLE with a lone load delays its grant by one cycle
        idle_vec(1, 1, 'hA00, 0, 0, 0, 0);
        idle_vec(0, 1, 'hA00, 0, 0, 0, 0);
        add(0, 0, 1, 'hA00, 0, 0, 0, 0, 1, 'h66, K_LD, 'hA00, 'h66, 0, 1);
        idle_vec(0, 0, 0, 0, 0, 0, 0);
        // flush during a store is ignored
        idle_vec(0, 0, 0, 1, 'hB00, 'h5A5A5A5A, 4'hF);
        add(0, 1, 0, 0, 1, 'hB00, 'h5A5A5A5A, 4'hF, 0, 0, K_ST, 'hB00, 'h5A5A5A5A, 4'hF, 0);
        add(0, 0, 0, 0, 1, 'hB00, 'h5A5A5A5A, 4'hF, 1, 0, K_ST, 'hB00, 'h5A5A5A5A, 4'hF, 1);
        idle_vec(0, 0, 0, 0, 0, 0, 0);
        // stray mem_resp in IDLE, then reset mid-transaction
        add(0, 0, 0, 0, 0, 0, 0, 0, 1, 'hFFFF, K_IDLE, 0, 0, 0, 0);
        idle_vec(0, 1, 'h900, 0, 0, 0, 0);
        add(1, 0, 1, 'h900, 0, 0, 0, 0, 0, 0, K_LD, 'h900, 0, 0, 0);
        idle_vec(0, 0, 0, 0, 0, 0, 0);

        repeat (2) @(posedge clk);
        foreach (vecs[i]) begin
            @(posedge clk);
            #1;
            rst = vecs[i].rst; flush = vecs[i].flush;
            ld_read = vecs[i].ld; ld_address = vecs[i].la;
            st_write = vecs[i].st; st_address = vecs[i].sa;
            st_wdata = vecs[i].sw; st_byte_enable = vecs[i].sb;
            mem_resp = vecs[i].mresp; mem_rdata = vecs[i].mrdata;
            @(negedge clk);
            e = expect_of(vecs[i]);
            check($sformatf("vec%0d", i), actual(), e);
        end

        // back-to-back spacing: next grant two cycles after the previous response
        @(posedge clk);
        #1;
        ld_read = 1; ld_address = 'hC00;
        st_write = 1; st_address = 'hC04; st_wdata = 'h1; st_byte_enable = 4'hF;
        found = 0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge clk);
            found = mem_write;
        end
        check("b2b_store_issue", {103'd0, found}, {103'd0, 1'b1});
        @(posedge clk);
        #1 mem_resp = 1;
        @(negedge clk);
        check("b2b_store_resp", {103'd0, st_resp}, {103'd0, 1'b1});
        @(posedge clk);
        #1;
        mem_resp = 0; st_write = 0;
        gap = 0;
        found = 0;
        for (int i = 1; i <= 10 && !found; i++) begin
            @(negedge clk);
            if (mem_read) begin
                found = 1;
                gap = i;
            end
        end
        check("b2b_gap", 104'(gap), 104'(2));
        @(posedge clk);
        #1;
        mem_resp = 1; mem_rdata = 'h13579BDF;
        @(negedge clk);
        check("b2b_load_resp", {71'd0, ld_resp, ld_rdata}, {71'd0, 1'b1, 32'h13579BDF});
        @(posedge clk);
        #1;
        mem_resp = 0; ld_read = 0; mem_rdata = 0;
        repeat (2) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
